// File: rtl/gsram_pkg.sv
// Shared definitions for the gsram grid: default geometry, FSM state type
// and an address-width helper.
package gsram_pkg;

    localparam int GSRAM_DATA_W = 16;
    localparam int GSRAM_ROWS   = 10;
    localparam int GSRAM_COLS   = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2
    } gsram_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int min_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gsram_seq_ctr.sv
// Row/column sequence counter used by both the zero-fill sweep and the row
// stream. A sweep walks every cell row-major; a row stream walks one row.
// The counter never wraps past its final position.
module gsram_seq_ctr
    import gsram_pkg::*;
#(
    parameter int ROWS = GSRAM_ROWS,
    parameter int COLS = GSRAM_COLS,
    localparam int RW = min_bits(ROWS),
    localparam int CW = min_bits(COLS)
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sweep_start,
    input  logic          row_start,
    input  logic [RW-1:0] start_row,
    input  logic          step,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          done
);

    logic [RW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic          single_reg;
    logic          col_last;
    logic          row_last;

    assign col_last = (col_reg == CW'(COLS - 1));
    assign row_last = (row_reg == RW'(ROWS - 1));
    assign done     = col_last && (single_reg || row_last);
    assign row      = row_reg;
    assign col      = col_reg;

    // Position register: load on start, advance on step until done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg    <= '0;
            col_reg    <= '0;
            single_reg <= 1'b0;
        end else if (sweep_start) begin
            row_reg    <= '0;
            col_reg    <= '0;
            single_reg <= 1'b0;
        end else if (row_start) begin
            row_reg    <= start_row;
            col_reg    <= '0;
            single_reg <= 1'b1;
        end else if (step && !done) begin
            if (col_last) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gsram_grid.sv
// ROWS x COLS grid memory with single-cell write/read, a zero-fill sweep and
// a row-stream mode. Reset starts an automatic sweep so the array is zeroed
// before the block accepts requests.
module gsram_grid
    import gsram_pkg::*;
#(
    parameter int DATA_W = GSRAM_DATA_W,
    parameter int ROWS   = GSRAM_ROWS,
    parameter int COLS   = GSRAM_COLS,
    localparam int RW = min_bits(ROWS),
    localparam int CW = min_bits(COLS)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [RW-1:0]     row,
    input  logic [CW-1:0]     col,
    input  logic              inmuxsel,
    input  logic [DATA_W-1:0] m2result,
    input  logic [DATA_W-1:0] lutdata,
    input  logic              clr,
    input  logic              strm,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rlast,
    output logic              busy,
    output logic              addr_err
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = min_bits(DEPTH);

    // Row-major storage, deliberately without reset.
    logic [DATA_W-1:0] mem [DEPTH];

    gsram_state_e state_reg, state_next;

    logic [RW-1:0]     ctr_row;
    logic [CW-1:0]     ctr_col;
    logic              ctr_done;
    logic              sweep_start;
    logic              row_start;
    logic              ctr_step;

    logic              req_row_ok;
    logic              req_col_ok;
    logic [AW-1:0]     req_idx;
    logic [AW-1:0]     ctr_idx;
    logic [DATA_W-1:0] wdata_sel;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_en;
    logic              rd_oor;
    logic [AW-1:0]     rd_addr;
    logic              rlast_next;
    logic              err_next;

    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;
    logic              rlast_reg;
    logic              addr_err_reg;

    assign req_row_ok = (int'(row) < ROWS);
    assign req_col_ok = (int'(col) < COLS);
    assign req_idx    = AW'(row) * AW'(COLS) + AW'(col);
    assign ctr_idx    = AW'(ctr_row) * AW'(COLS) + AW'(ctr_col);
    assign wdata_sel  = inmuxsel ? lutdata : m2result;

    assign rdata    = rdata_reg;
    assign rvalid   = rvalid_reg;
    assign rlast    = rlast_reg;
    assign addr_err = addr_err_reg;
    assign busy     = (state_reg != ST_IDLE);

    gsram_seq_ctr #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_seq_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .sweep_start (sweep_start),
        .row_start   (row_start),
        .start_row   (row),
        .step        (ctr_step),
        .row         (ctr_row),
        .col         (ctr_col),
        .done        (ctr_done)
    );

    // State register; reset lands in CLEAR so the array is always zeroed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_CLEAR;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath control: one request acts per idle cycle.
    always_comb begin
        state_next  = state_reg;
        sweep_start = 1'b0;
        row_start   = 1'b0;
        ctr_step    = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = req_idx;
        mem_wdata   = wdata_sel;
        rd_en       = 1'b0;
        rd_oor      = 1'b0;
        rd_addr     = req_idx;
        rlast_next  = 1'b0;
        err_next    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (clr) begin
                    state_next  = ST_CLEAR;
                    sweep_start = 1'b1;
                end else if (strm) begin
                    if (req_row_ok) begin
                        state_next = ST_STREAM;
                        row_start  = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (we) begin
                    if (req_row_ok && req_col_ok) begin
                        mem_we = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (re) begin
                    if (req_row_ok && req_col_ok) begin
                        rd_en = 1'b1;
                    end else begin
                        rd_oor   = 1'b1;
                        err_next = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ctr_idx;
                mem_wdata = '0;
                ctr_step  = 1'b1;
                if (ctr_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STREAM: begin
                rd_en      = 1'b1;
                rd_addr    = ctr_idx;
                rlast_next = ctr_done;
                ctr_step   = 1'b1;
                if (ctr_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // Array write port (single-cell writes and sweep zero-fill).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read/status outputs; rdata holds between valid beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg    <= '0;
            rvalid_reg   <= 1'b0;
            rlast_reg    <= 1'b0;
            addr_err_reg <= 1'b0;
        end else begin
            rvalid_reg   <= rd_en | rd_oor;
            rlast_reg    <= rlast_next;
            addr_err_reg <= err_next;
            if (rd_en) begin
                rdata_reg <= mem[rd_addr];
            end else if (rd_oor) begin
                rdata_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gsram_grid.sv
// Scoreboard bench for gsram_grid: stimulus pushes expected read beats, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_gsram_grid;

    localparam int DW   = 16;
    localparam int ROWS = 10;
    localparam int COLS = 10;
    localparam int RW   = 4;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [RW-1:0] row = '0;
    logic [CW-1:0] col = '0;
    logic          inmuxsel = 1'b0;
    logic [DW-1:0] m2result = '0;
    logic [DW-1:0] lutdata = '0;
    logic          clr = 1'b0;
    logic          strm = 1'b0;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rlast;
    logic          busy;
    logic          addr_err;

    gsram_grid dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .re       (re),
        .row      (row),
        .col      (col),
        .inmuxsel (inmuxsel),
        .m2result (m2result),
        .lutdata  (lutdata),
        .clr      (clr),
        .strm     (strm),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rlast    (rlast),
        .busy     (busy),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [ROWS][COLS];
    int            checks = 0;
    int            failures = 0;
    int            err_expected = 0;
    int            err_seen = 0;
    logic [DW-1:0] held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = '0;
    endtask

    // Counts cycles with busy high (bounded) and compares to the expected length.
    task automatic expect_busy(input string name, input int len);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        check(name, n, len);
    endtask

    task automatic do_write(input int r, input int c, input logic sel, input logic [DW-1:0] d);
        we = 1'b1;
        row = RW'(r);
        col = CW'(c);
        inmuxsel = sel;
        if (sel) begin
            lutdata = d;
            m2result = ~d;
        end else begin
            m2result = d;
            lutdata = ~d;
        end
        if (r < ROWS && c < COLS) model[r][c] = d;
        else err_expected++;
        tick();
        we = 1'b0;
    endtask

    task automatic do_read(input int r, input int c);
        exp_t e;
        re = 1'b1;
        row = RW'(r);
        col = CW'(c);
        e.last = 1'b0;
        if (r < ROWS && c < COLS) begin
            e.data = model[r][c];
            e.err = 1'b0;
        end else begin
            e.data = '0;
            e.err = 1'b1;
            err_expected++;
        end
        exp_q.push_back(e);
        tick();
        re = 1'b0;
    endtask

    task automatic do_stream(input int r);
        exp_t e;
        strm = 1'b1;
        row = RW'(r);
        if (r < ROWS) begin
            for (int c = 0; c < COLS; c++) begin
                e.data = model[r][c];
                e.last = (c == COLS - 1);
                e.err = 1'b0;
                exp_q.push_back(e);
            end
        end
        tick();
        strm = 1'b0;
        if (r < ROWS) begin
            expect_busy("stream_busy_cycles", COLS);
        end else begin
            err_expected++;
            check("strm_oor_busy", busy, 0);
            tick();
            check("strm_oor_busy_after", busy, 0);
        end
    endtask

    // Monitor: compare every valid beat against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = '0;
        end else begin
            if (addr_err) err_seen++;
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rvalid actual=rdata %0h required=no beat", rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", rdata, e.data);
                    check("rlast", rlast, e.last);
                    check("read_addr_err", addr_err, e.err);
                end
                held = rdata;
            end else begin
                check("rdata_hold", rdata, held);
                check("rlast_idle", rlast, 0);
            end
        end
    end

    initial begin
        int op, r, c;
        logic [DW-1:0] d;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rlast", rlast, 0);
        check("rst_addr_err", addr_err, 0);
        rst_n = 1'b1;
        model_zero();
        expect_busy("reset_sweep_cycles", ROWS * COLS);
        do_read(9, 9);

        // Mux source selection with read-after-write
        do_write(3, 4, 1'b1, 16'hBEEF);
        do_read(3, 4);
        do_write(3, 4, 1'b0, 16'h1234);
        do_read(3, 4);

        // Row stream
        for (int i = 0; i < COLS; i++) do_write(2, i, i[0], DW'(16'h0200 + i));
        do_stream(2);

        // Out-of-range requests
        do_write(10, 0, 1'b1, 16'hDEAD);
        do_read(0, 12);
        do_read(0, 0);
        do_stream(11);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 19));
            r = (($urandom_range(0, 7)) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, ROWS - 1));
            c = (($urandom_range(0, 7)) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, COLS - 1));
            d = DW'($urandom);
            if (op < 9) do_write(r, c, 1'($urandom_range(0, 1)), d);
            else if (op < 18) do_read(r, c);
            else if (op == 18) do_stream(r);
            else tick();
        end

        // clr beats a same-cycle write; requests during the sweep are ignored
        clr = 1'b1;
        we = 1'b1;
        row = 4'd1;
        col = 4'd1;
        inmuxsel = 1'b1;
        lutdata = 16'hAAAA;
        tick();
        clr = 1'b0;
        model_zero();
        check("clr_busy", busy, 1);
        begin
            int n;
            n = 0;
            re = 1'b1;
            strm = 1'b1;
            while (busy && n < 1000) begin
                row = RW'($urandom_range(0, ROWS - 1));
                col = CW'($urandom_range(0, COLS - 1));
                tick();
                n++;
            end
            we = 1'b0;
            re = 1'b0;
            strm = 1'b0;
            check("clr_busy_cycles", n, ROWS * COLS);
        end
        for (int i = 0; i < ROWS; i++) do_stream(i);

        // Reset in the middle of a stream
        for (int i = 0; i < COLS; i++) do_write(2, i, 1'b0, DW'($urandom));
        do_stream(5);
        strm = 1'b1;
        row = 4'd2;
        tick();
        strm = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            exp_t e;
            e.data = model[2][i];
            e.last = (i == COLS - 1);
            e.err = 1'b0;
            exp_q.push_back(e);
        end
        repeat (4) tick();
        check("beat4_rvalid", rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", rvalid, 0);
        check("midrst_busy", busy, 1);
        check("midrst_rdata", rdata, 0);
        exp_q.delete();
        model_zero();
        tick();
        rst_n = 1'b1;
        expect_busy("midrst_sweep_cycles", ROWS * COLS);
        do_stream(2);
        do_read(9, 9);

        // Drain and final accounting
        repeat (5) tick();
        check("queue_drained", exp_q.size(), 0);
        check("addr_err_pulses", err_seen, err_expected);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
